// File: rtl/aemb2_xsl_pkg.sv
// XSL responder shared types: data width, channel width helper and
// the packed FIFO entry layout {chn, ctl, dat}.
package aemb2_xsl_pkg;

  localparam int XSL_DW = 32;

  function automatic int chn_w(input int xwb);
    return xwb - 2;
  endfunction

  typedef struct packed {
    logic              ctl;
    logic [XSL_DW-1:0] dat;
  } xsl_word_t;

  localparam int WORD_W = $bits(xsl_word_t);

endpackage

// File: rtl/aemb2_xsl_resp_if.sv
// XSL bus between the core initiator (master) and the responder (slave).
// Suffixes name the direction as seen from the responder.
interface aemb2_xsl_resp_if #(
  parameter int AEMB_XWB = 3
);
  import aemb2_xsl_pkg::*;

  localparam int CW = chn_w(AEMB_XWB);

  logic [CW-1:0]     xwb_adr_i;
  logic [XSL_DW-1:0] xwb_dat_i;
  logic [3:0]        xwb_sel_i;
  logic              xwb_tag_i;
  logic              xwb_stb_i;
  logic              xwb_cyc_i;
  logic              xwb_wre_i;
  logic [XSL_DW-1:0] xwb_dat_o;
  logic              xwb_ack_o;

  modport master (
    output xwb_adr_i,
    output xwb_dat_i,
    output xwb_sel_i,
    output xwb_tag_i,
    output xwb_stb_i,
    output xwb_cyc_i,
    output xwb_wre_i,
    input  xwb_dat_o,
    input  xwb_ack_o
  );

  modport slave (
    input  xwb_adr_i,
    input  xwb_dat_i,
    input  xwb_sel_i,
    input  xwb_tag_i,
    input  xwb_stb_i,
    input  xwb_cyc_i,
    input  xwb_wre_i,
    output xwb_dat_o,
    output xwb_ack_o
  );

endinterface

// File: rtl/aemb2_xsl_sfifo.sv
// Show-ahead synchronous FIFO; head word is always on rdat.
// Overflow/underflow requests are dropped internally.
module aemb2_xsl_sfifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == LP_FULL);
  assign count = r_cnt;
  assign rdat  = r_mem[r_rp];

  // a full FIFO still accepts a push when the head leaves this cycle
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= wdat;
  end

endmodule

// File: rtl/aemb2_xsl_resp.sv
// XSL responder: terminates GET/PUT cycles and bridges them to
// PUT (core->accel) and GET (accel->core) valid/ready streams.
module aemb2_xsl_resp import aemb2_xsl_pkg::*; #(
  parameter int AEMB_XWB = 3,
  parameter int DEPTH    = 4,
  parameter int AW       = 2
) (
  input  logic                gclk,
  input  logic                grst,
  aemb2_xsl_resp_if.slave     xwb,
  output logic [XSL_DW-1:0]   put_dat_o,
  output logic [AEMB_XWB-3:0] put_chn_o,
  output logic                put_ctl_o,
  output logic                put_vld_o,
  input  logic                put_rdy_i,
  input  logic [XSL_DW-1:0]   get_dat_i,
  input  logic [AEMB_XWB-3:0] get_chn_i,
  input  logic                get_ctl_i,
  input  logic                get_vld_i,
  output logic                get_rdy_o
);

  localparam int CW = chn_w(AEMB_XWB);
  localparam int EW = CW + WORD_W;

  logic              r_ack;
  logic [XSL_DW-1:0] r_dat;

  logic              w_req;
  logic              w_put_acc;
  logic              w_get_acc;
  logic              w_put_pop;
  logic              w_get_push;
  logic              w_put_full;
  logic              w_put_empty;
  logic              w_get_full;
  logic              w_get_empty;
  logic [AW:0]       w_put_cnt;
  logic [AW:0]       w_get_cnt;
  logic [EW-1:0]     w_put_wdat;
  logic [EW-1:0]     w_put_rdat;
  logic [EW-1:0]     w_get_wdat;
  logic [EW-1:0]     w_get_rdat;
  logic [CW-1:0]     w_get_chn;
  xsl_word_t         w_put_word;
  xsl_word_t         w_get_word;
  logic              w_unused;

  // ack gate keeps a still-high stb in the ack cycle from re-firing
  assign w_req = xwb.xwb_stb_i & xwb.xwb_cyc_i & ~r_ack;

  assign w_put_pop  = ~w_put_empty & put_rdy_i;
  assign w_get_push = get_vld_i & ~w_get_full;

  assign w_put_acc = w_req & xwb.xwb_wre_i
                   & (~w_put_full | w_put_pop);
  assign w_get_acc = w_req & ~xwb.xwb_wre_i & ~w_get_empty
                   & (w_get_chn == xwb.xwb_adr_i);

  assign w_put_wdat = {xwb.xwb_adr_i, xwb.xwb_tag_i, xwb.xwb_dat_i};
  assign w_get_wdat = {get_chn_i, get_ctl_i, get_dat_i};

  assign {put_chn_o, w_put_word} = w_put_rdat;
  assign {w_get_chn, w_get_word} = w_get_rdat;

  assign put_dat_o = w_put_word.dat;
  assign put_ctl_o = w_put_word.ctl;
  assign put_vld_o = ~w_put_empty;
  assign get_rdy_o = ~w_get_full;

  assign xwb.xwb_ack_o = r_ack;
  assign xwb.xwb_dat_o = r_dat;

  // sel is always all-ones and the GET control bit has no consumer
  assign w_unused = ^{xwb.xwb_sel_i, w_get_word.ctl, w_put_cnt, w_get_cnt};

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_put_acc | w_get_acc;
      if (w_get_acc) r_dat <= w_get_word.dat;
    end
  end

  aemb2_xsl_sfifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_put_fifo (
    .clk   (gclk),
    .rst_n (grst),
    .push  (w_put_acc),
    .wdat  (w_put_wdat),
    .pop   (w_put_pop),
    .rdat  (w_put_rdat),
    .full  (w_put_full),
    .empty (w_put_empty),
    .count (w_put_cnt)
  );

  aemb2_xsl_sfifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_get_fifo (
    .clk   (gclk),
    .rst_n (grst),
    .push  (w_get_push),
    .wdat  (w_get_wdat),
    .pop   (w_get_acc),
    .rdat  (w_get_rdat),
    .full  (w_get_full),
    .empty (w_get_empty),
    .count (w_get_cnt)
  );

endmodule

// File: tb/tb_aemb2_xsl_resp.sv
// Bench for aemb2_xsl_resp: vector table, corner sequences and a
// randomized run against a queue-based model of the responder.
module tb_aemb2_xsl_resp;

  localparam int DEPTH = 4;

  typedef struct {
    logic        wre;
    logic [0:0]  chn;
    logic        ctl;
    logic [31:0] dat;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [0:0]  chn;
    logic        ctl;
    logic [31:0] dat;
  } ent_t;

  logic        gclk = 1'b0;
  logic        grst = 1'b0;
  logic [31:0] put_dat_o;
  logic [0:0]  put_chn_o;
  logic        put_ctl_o;
  logic        put_vld_o;
  logic        put_rdy_i = 1'b0;
  logic [31:0] get_dat_i = '0;
  logic [0:0]  get_chn_i = '0;
  logic        get_ctl_i = 1'b0;
  logic        get_vld_i = 1'b0;
  logic        get_rdy_o;

  int n_chk  = 0;
  int n_fail = 0;

  aemb2_xsl_resp_if #(.AEMB_XWB(3)) bus ();

  aemb2_xsl_resp #(
    .AEMB_XWB (3),
    .DEPTH    (DEPTH),
    .AW       (2)
  ) dut (
    .gclk      (gclk),
    .grst      (grst),
    .xwb       (bus),
    .put_dat_o (put_dat_o),
    .put_chn_o (put_chn_o),
    .put_ctl_o (put_ctl_o),
    .put_vld_o (put_vld_o),
    .put_rdy_i (put_rdy_i),
    .get_dat_i (get_dat_i),
    .get_chn_i (get_chn_i),
    .get_ctl_i (get_ctl_i),
    .get_vld_i (get_vld_i),
    .get_rdy_o (get_rdy_o)
  );

  always #5 gclk = ~gclk;

  initial begin
    #500000;
    $display("FAIL watchdog: no finish (act timeout, req finish)");
    $fatal(1);
  end

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic wre, input logic [0:0] chn,
                         input logic ctl, input logic [31:0] dat);
    bus.xwb_wre_i = wre;
    bus.xwb_adr_i = chn;
    bus.xwb_tag_i = ctl;
    bus.xwb_dat_i = dat;
    bus.xwb_cyc_i = 1'b1;
    bus.xwb_stb_i = 1'b1;
  endtask

  // returns at the sample where ack is seen; lat=-1 on timeout
  task automatic do_xfer(input logic wre, input logic [0:0] chn,
                         input logic ctl, input logic [31:0] dat,
                         input int maxc, output int lat);
    set_req(wre, chn, ctl, dat);
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (bus.xwb_ack_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus.xwb_stb_i = 1'b0;
  endtask

  task automatic offer_get(input logic [0:0] chn, input logic ctl,
                           input logic [31:0] dat);
    get_chn_i = chn;
    get_ctl_i = ctl;
    get_dat_i = dat;
    get_vld_i = 1'b1;
    tick();
    get_vld_i = 1'b0;
  endtask

  vec_t vt[6];
  ent_t mq_put[$];
  ent_t mq_get[$];

  initial begin
    int   lat;
    int   nack;
    logic got;
    logic mack;
    logic [31:0] mdat;
    logic pending;
    logic req, ppop, gpush, pacc, gacc;
    ent_t e;

    vt[0] = '{1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 1};
    vt[2] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1};
    vt[3] = '{1'b0, 1'b0, 1'b1, 32'h12345678, 1};
    vt[4] = '{1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 1};
    vt[5] = '{1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1};

    bus.xwb_sel_i = 4'hF;
    bus.xwb_stb_i = 1'b0;
    bus.xwb_cyc_i = 1'b0;
    bus.xwb_wre_i = 1'b0;
    bus.xwb_tag_i = 1'b0;
    bus.xwb_adr_i = '0;
    bus.xwb_dat_i = '0;

    // reset held with a PUT pending
    set_req(1'b1, 1'b1, 1'b0, 32'hA5A50001);
    repeat (3) tick();
    check("rst_ack", bus.xwb_ack_o, 0);
    check("rst_dat", bus.xwb_dat_o, 0);
    check("rst_put_vld", put_vld_o, 0);
    check("rst_get_rdy", get_rdy_o, 1);
    grst = 1'b1;
    tick();
    check("rst_rel_ack", bus.xwb_ack_o, 1);
    check("rst_rel_put_dat", put_dat_o, 32'hA5A50001);
    bus.xwb_stb_i = 1'b0;
    put_rdy_i = 1'b1;
    tick();
    check("rst_rel_ack_fall", bus.xwb_ack_o, 0);
    tick();
    put_rdy_i = 1'b0;
    check("rst_rel_drain", put_vld_o, 0);

    // vector table
    foreach (vt[i]) begin
      if (vt[i].wre) begin
        put_rdy_i = 1'b1;
        do_xfer(1'b1, vt[i].chn, vt[i].ctl, vt[i].dat, 5, lat);
        check($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
        check($sformatf("v%0d_vld", i), put_vld_o, 1);
        check($sformatf("v%0d_chn", i), put_chn_o, vt[i].chn);
        check($sformatf("v%0d_ctl", i), put_ctl_o, vt[i].ctl);
        check($sformatf("v%0d_dat", i), put_dat_o, vt[i].dat);
        tick();
        check($sformatf("v%0d_popped", i), put_vld_o, 0);
        put_rdy_i = 1'b0;
      end else begin
        offer_get(vt[i].chn, vt[i].ctl, vt[i].dat);
        do_xfer(1'b0, vt[i].chn, 1'b0, 32'h0, 5, lat);
        check($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
        check($sformatf("v%0d_xdat", i), bus.xwb_dat_o, vt[i].dat);
        tick();
      end
      check($sformatf("v%0d_ack_fall", i), bus.xwb_ack_o, 0);
    end

    // fill PUT FIFO, fifth stalls until the head leaves
    for (int i = 1; i <= 4; i++) begin
      do_xfer(1'b1, 1'(i), 1'b0, 32'(i), 5, lat);
      check($sformatf("fill%0d_lat", i), lat, 1);
      tick();
    end
    set_req(1'b1, 1'b1, 1'b0, 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fill5_stall", bus.xwb_ack_o, 0);
    end
    put_rdy_i = 1'b1;
    tick();
    put_rdy_i = 1'b0;
    check("fill5_ack", bus.xwb_ack_o, 1);
    check("fill5_head", put_dat_o, 2);
    bus.xwb_stb_i = 1'b0;
    tick();
    put_rdy_i = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("order%0d_vld", k), put_vld_o, 1);
      check($sformatf("order%0d_dat", k), put_dat_o, 32'(k));
      tick();
    end
    put_rdy_i = 1'b0;
    check("order_empty", put_vld_o, 0);

    // GET on empty FIFO stalls, then completes once a word arrives
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gempty_stall", bus.xwb_ack_o, 0);
    end
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        get_chn_i = 1'b0;
        get_ctl_i = 1'b0;
        get_dat_i = 32'h12345678;
        get_vld_i = 1'b1;
      end
      tick();
      get_vld_i = 1'b0;
      if (bus.xwb_ack_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("gempty_ack", got, 1);
    check("gempty_dat", bus.xwb_dat_o, 32'h12345678);
    bus.xwb_stb_i = 1'b0;
    tick();
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    nack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.xwb_ack_o === 1'b1) nack++;
    end
    check("gempty_again", nack, 0);
    bus.xwb_stb_i = 1'b0;
    tick();

    // channel mismatch holds off the GET
    offer_get(1'b0, 1'b1, 32'h0BADC0DE);
    set_req(1'b0, 1'b1, 1'b0, 32'h0);
    nack = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.xwb_ack_o === 1'b1) nack++;
    end
    check("mismatch_noack", nack, 0);
    check("mismatch_dat_hold", bus.xwb_dat_o, 32'h12345678);
    bus.xwb_adr_i = 1'b0;
    tick();
    check("match_ack", bus.xwb_ack_o, 1);
    check("match_dat", bus.xwb_dat_o, 32'h0BADC0DE);
    bus.xwb_stb_i = 1'b0;
    tick();

    // stb held one cycle past ack: single PUT push
    set_req(1'b1, 1'b0, 1'b1, 32'h5A5A5A5A);
    tick();
    check("b2b_put_ack", bus.xwb_ack_o, 1);
    tick();
    check("b2b_put_noack", bus.xwb_ack_o, 0);
    bus.xwb_stb_i = 1'b0;
    tick();
    check("b2b_put_noack2", bus.xwb_ack_o, 0);
    check("b2b_put_vld", put_vld_o, 1);
    put_rdy_i = 1'b1;
    tick();
    put_rdy_i = 1'b0;
    check("b2b_put_one", put_vld_o, 0);

    // stb held one cycle past ack: single GET pop
    offer_get(1'b0, 1'b0, 32'hAAAA0001);
    offer_get(1'b0, 1'b0, 32'hAAAA0002);
    set_req(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("b2b_get_ack", bus.xwb_ack_o, 1);
    check("b2b_get_dat", bus.xwb_dat_o, 32'hAAAA0001);
    tick();
    check("b2b_get_noack", bus.xwb_ack_o, 0);
    bus.xwb_stb_i = 1'b0;
    tick();
    check("b2b_get_hold", bus.xwb_dat_o, 32'hAAAA0001);
    do_xfer(1'b0, 1'b0, 1'b0, 32'h0, 5, lat);
    check("b2b_get2_lat", lat, 1);
    check("b2b_get2_dat", bus.xwb_dat_o, 32'hAAAA0002);
    tick();

    // randomized run against a queue model, from a fresh reset
    grst = 1'b0;
    #2;
    grst = 1'b1;
    tick();
    mq_put.delete();
    mq_get.delete();
    mack = 1'b0;
    mdat = '0;
    pending = 1'b0;
    bus.xwb_stb_i = 1'b0;
    for (int c = 0; c < 800; c++) begin
      put_rdy_i = ($urandom_range(0, 2) == 0);
      get_vld_i = ($urandom_range(0, 2) == 0);
      get_chn_i = 1'($urandom_range(0, 1));
      get_ctl_i = 1'($urandom_range(0, 1));
      get_dat_i = $urandom;
      if (pending && mack) begin
        bus.xwb_stb_i = 1'b0;
        pending = 1'b0;
      end else if (pending && $urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 1) bus.xwb_stb_i = 1'b0;
        else bus.xwb_cyc_i = 1'b0;
        pending = 1'b0;
      end else if (!pending && $urandom_range(0, 1) == 1) begin
        set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom);
        pending = 1'b1;
      end
      @(posedge gclk);
      req   = bus.xwb_stb_i & bus.xwb_cyc_i & ~mack;
      ppop  = (mq_put.size() > 0) && put_rdy_i;
      gpush = get_vld_i && (mq_get.size() < DEPTH);
      pacc  = req && bus.xwb_wre_i && (mq_put.size() < DEPTH || ppop);
      gacc  = req && !bus.xwb_wre_i && (mq_get.size() > 0)
              && (mq_get[0].chn == bus.xwb_adr_i);
      if (ppop) void'(mq_put.pop_front());
      if (pacc) begin
        e.chn = bus.xwb_adr_i;
        e.ctl = bus.xwb_tag_i;
        e.dat = bus.xwb_dat_i;
        mq_put.push_back(e);
      end
      if (gacc) begin
        mdat = mq_get[0].dat;
        void'(mq_get.pop_front());
      end
      if (gpush) begin
        e.chn = get_chn_i;
        e.ctl = get_ctl_i;
        e.dat = get_dat_i;
        mq_get.push_back(e);
      end
      mack = pacc || gacc;
      #1;
      check("rnd_ack", bus.xwb_ack_o, mack);
      check("rnd_xdat", bus.xwb_dat_o, mdat);
      check("rnd_put_vld", put_vld_o, mq_put.size() > 0);
      check("rnd_get_rdy", get_rdy_o, mq_get.size() < DEPTH);
      if (mq_put.size() > 0) begin
        check("rnd_put_dat", put_dat_o, mq_put[0].dat);
        check("rnd_put_chn", put_chn_o, mq_put[0].chn);
        check("rnd_put_ctl", put_ctl_o, mq_put[0].ctl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
